// File: rtl/smem_core_port_if.sv
// Core-side request/response channel and shared-memory lane of one smem_core_port.
// slave = the port block itself, master = the core LSU / memory environment around it.
`timescale 1ns/1ps
interface smem_core_port_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              resp_valid;
   logic              resp_ready;
   logic              resp_write;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   logic              sm_read;
   logic              sm_write;
   logic              sm_core_val;
   logic [ADDR_W-1:0] sm_addr;
   logic [DATA_W-1:0] sm_wdata;
   logic [DATA_W-1:0] sm_rdata;
   logic              sm_finish;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready, sm_rdata, sm_finish,
      output req_ready, resp_valid, resp_write, resp_rdata, resp_err,
             sm_read, sm_write, sm_core_val, sm_addr, sm_wdata
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready, sm_rdata, sm_finish,
      input  req_ready, resp_valid, resp_write, resp_rdata, resp_err,
             sm_read, sm_write, sm_core_val, sm_addr, sm_wdata
   );
endinterface

// File: rtl/smem_core_port.sv
// Per-core front-end to the shared memory: in-order request FIFO, single-outstanding issue FSM, response channel.
// Optional busy-timeout abort is compiled in with `define SMEM_TIMEOUT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no request in flight; pops FIFO head into issue registers
// ST_BUSY  | strobes driven to shared memory, waiting for sm_finish
// ST_RESP  | response presented to core, waiting for resp_ready
// ST_DRAIN | response taken but sm_finish still high; wait for it to drop
`timescale 1ns/1ps
module smem_core_port #(
   parameter int ADDR_W         = 12,
   parameter int DATA_W         = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clock,
   input  logic              reset,
   smem_core_port_if.slave   bus,
   output logic              busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("smem_core_port: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
   end

   logic [PTR_W:0]          wr_ptr;
   logic [PTR_W:0]          rd_ptr;
   logic [FIFO_DEPTH-1:0]   fifo_write;
   logic [ADDR_W-1:0]       fifo_addr  [FIFO_DEPTH];
   logic [DATA_W-1:0]       fifo_wdata [FIFO_DEPTH];
   logic                    empty;
   logic                    full;
   logic                    push;
   logic                    pop;

   logic [1:0]              state;
   logic                    iss_write;
   logic [ADDR_W-1:0]       iss_addr;
   logic [DATA_W-1:0]       iss_wdata;

   logic                    sm_read_q;
   logic                    sm_write_q;
   logic                    sm_core_val_q;
   logic [ADDR_W-1:0]       sm_addr_q;
   logic [DATA_W-1:0]       sm_wdata_q;

   logic                    resp_valid_q;
   logic                    resp_write_q;
   logic [DATA_W-1:0]       resp_rdata_q;

   // Wrap bits differ and index bits match: every entry is occupied.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign push  = bus.req_valid && !full;
   assign pop   = (state == ST_IDLE) && !empty;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_write[wr_ptr[PTR_W-1:0]] <= bus.req_write;
         fifo_addr[wr_ptr[PTR_W-1:0]]  <= bus.req_addr;
         fifo_wdata[wr_ptr[PTR_W-1:0]] <= bus.req_wdata;
      end
   end

`ifdef SMEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] tmo_cnt;
   logic             resp_err_q;

   assign bus.resp_err = resp_err_q;
`else
   assign bus.resp_err = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         iss_write     <= 1'b0;
         iss_addr      <= '0;
         iss_wdata     <= '0;
         sm_read_q     <= 1'b0;
         sm_write_q    <= 1'b0;
         sm_core_val_q <= 1'b0;
         sm_addr_q     <= '0;
         sm_wdata_q    <= '0;
         resp_valid_q  <= 1'b0;
         resp_write_q  <= 1'b0;
         resp_rdata_q  <= '0;
`ifdef SMEM_TIMEOUT_EN
         tmo_cnt       <= '0;
         resp_err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  iss_write <= fifo_write[rd_ptr[PTR_W-1:0]];
                  iss_addr  <= fifo_addr[rd_ptr[PTR_W-1:0]];
                  iss_wdata <= fifo_wdata[rd_ptr[PTR_W-1:0]];
                  state     <= ST_BUSY;
`ifdef SMEM_TIMEOUT_EN
                  tmo_cnt   <= '0;
`endif
               end
            end
            ST_BUSY: begin
               // First BUSY cycle launches the lane; finish is only honoured once strobes are out.
               if (!sm_core_val_q) begin
                  sm_core_val_q <= 1'b1;
                  sm_read_q     <= !iss_write;
                  sm_write_q    <= iss_write;
                  sm_addr_q     <= iss_addr;
                  sm_wdata_q    <= iss_wdata;
               end else if (bus.sm_finish) begin
                  sm_core_val_q <= 1'b0;
                  sm_read_q     <= 1'b0;
                  sm_write_q    <= 1'b0;
                  resp_valid_q  <= 1'b1;
                  resp_write_q  <= iss_write;
                  resp_rdata_q  <= iss_write ? '0 : bus.sm_rdata;
`ifdef SMEM_TIMEOUT_EN
                  resp_err_q    <= 1'b0;
`endif
                  state         <= ST_RESP;
               end
`ifdef SMEM_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  sm_core_val_q <= 1'b0;
                  sm_read_q     <= 1'b0;
                  sm_write_q    <= 1'b0;
                  resp_valid_q  <= 1'b1;
                  resp_write_q  <= iss_write;
                  resp_rdata_q  <= '0;
                  resp_err_q    <= 1'b1;
                  state         <= ST_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state        <= bus.sm_finish ? ST_DRAIN : ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (!bus.sm_finish) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready   = !full;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_write  = resp_write_q;
   assign bus.resp_rdata  = resp_rdata_q;
   assign bus.sm_read     = sm_read_q;
   assign bus.sm_write    = sm_write_q;
   assign bus.sm_core_val = sm_core_val_q;
   assign bus.sm_addr     = sm_addr_q;
   assign bus.sm_wdata    = sm_wdata_q;

   assign busy = !empty || (state != ST_IDLE);

endmodule

// File: tb/tb_smem_core_port.sv
// Self-checking bench for smem_core_port: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_smem_core_port;
   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int TMO        = 16;

   logic clock = 1'b0;
   logic reset;
   logic busy;

   int checks = 0;
   int errors = 0;

   smem_core_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   smem_core_port #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(negedge clock);
      bus.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.resp_ready = 1'b0;
      bus.sm_rdata  = '0;
      bus.sm_finish = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({bus.req_ready, bus.resp_valid, bus.resp_write, bus.resp_err,
           bus.sm_read, bus.sm_write, bus.sm_core_val, busy} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 10000000", {bus.req_ready, bus.resp_valid,
                  bus.resp_write, bus.resp_err, bus.sm_read, bus.sm_write, bus.sm_core_val, busy});
      end
      checks++;
      if ({bus.sm_addr, bus.sm_wdata, bus.resp_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want all 0", bus.sm_addr, bus.sm_wdata, bus.resp_rdata);
      end
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_store();
      bus.resp_ready = 1'b1;
      checks++;
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL store_ready: got %b want 1", bus.req_ready); end
      send_req(1'b1, 12'h123, 8'hA5);
      checks++;
      if ({bus.sm_core_val, busy} !== 2'b01) begin
         errors++; $display("FAIL store_cyc1: core_val,busy=%b want 01", {bus.sm_core_val, busy});
      end
      @(negedge clock);
      checks++;
      if (bus.sm_core_val !== 1'b0) begin errors++; $display("FAIL store_cyc2: core_val=%b want 0", bus.sm_core_val); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checks++;
         if ({bus.sm_core_val, bus.sm_write, bus.sm_read, bus.sm_addr, bus.sm_wdata} !== {3'b110, 12'h123, 8'hA5}) begin
            errors++;
            $display("FAIL store_strobe[%0d]: val/wr/rd=%b%b%b addr=%h wdata=%h want 110 123 a5", k,
                     bus.sm_core_val, bus.sm_write, bus.sm_read, bus.sm_addr, bus.sm_wdata);
         end
      end
      bus.sm_finish = 1'b1;
      bus.sm_rdata  = 8'hEE;
      @(negedge clock);
      bus.sm_finish = 1'b0;
      checks++;
      if ({bus.sm_core_val, bus.sm_write, bus.resp_valid, bus.resp_write, bus.resp_err, bus.resp_rdata} !==
          {5'b00110, 8'h00}) begin
         errors++;
         $display("FAIL store_resp: val=%b wr=%b rv=%b rw=%b err=%b rdata=%h want 0 0 1 1 0 00", bus.sm_core_val,
                  bus.sm_write, bus.resp_valid, bus.resp_write, bus.resp_err, bus.resp_rdata);
      end
      @(negedge clock);
      checks++;
      if ({bus.resp_valid, busy} !== 2'b00) begin
         errors++; $display("FAIL store_done: resp_valid,busy=%b want 00", {bus.resp_valid, busy});
      end
   endtask

   task automatic test_load_drain();
      int n;
      int first;
      bus.resp_ready = 1'b1;
      send_req(1'b0, 12'h3C4, 8'h00);
      send_req(1'b1, 12'h055, 8'h11);
      n = 0;
      while (!bus.sm_core_val && n < 20) begin @(negedge clock); n++; end
      checks++;
      if ({bus.sm_core_val, bus.sm_read, bus.sm_write, bus.sm_addr} !== {3'b110, 12'h3C4}) begin
         errors++; $display("FAIL load_strobe: val/rd/wr=%b%b%b addr=%h want 110 3c4",
                            bus.sm_core_val, bus.sm_read, bus.sm_write, bus.sm_addr);
      end
      bus.sm_finish = 1'b1;
      bus.sm_rdata  = 8'h5C;
      @(negedge clock);
      checks++;
      if ({bus.resp_valid, bus.resp_write, bus.resp_err, bus.resp_rdata} !== {3'b100, 8'h5C}) begin
         errors++; $display("FAIL load_resp: rv=%b rw=%b err=%b rdata=%h want 1 0 0 5c",
                            bus.resp_valid, bus.resp_write, bus.resp_err, bus.resp_rdata);
      end
      bus.sm_rdata = 8'hC3;
      repeat (3) begin
         @(negedge clock);
         checks++;
         if ({bus.sm_core_val, bus.resp_valid} !== 2'b00) begin
            errors++; $display("FAIL load_drain_hold: core_val,resp_valid=%b want 00", {bus.sm_core_val, bus.resp_valid});
         end
      end
      bus.sm_finish = 1'b0;
      first = -1;
      for (int c = 1; c <= 20 && first < 0; c++) begin
         @(negedge clock);
         if (bus.sm_core_val) first = c;
      end
      checks++;
      if (first != 3) begin errors++; $display("FAIL drain_restart: next strobe after %0d cycles want 3", first); end
      checks++;
      if ({bus.sm_write, bus.sm_read, bus.sm_addr, bus.sm_wdata} !== {2'b10, 12'h055, 8'h11}) begin
         errors++; $display("FAIL drain_next_req: wr/rd=%b%b addr=%h wdata=%h want 10 055 11",
                            bus.sm_write, bus.sm_read, bus.sm_addr, bus.sm_wdata);
      end
      bus.sm_finish = 1'b1;
      @(negedge clock);
      bus.sm_finish = 1'b0;
      checks++;
      if ({bus.resp_valid, bus.resp_write, bus.resp_rdata} !== {2'b11, 8'h00}) begin
         errors++; $display("FAIL drain_store_resp: rv=%b rw=%b rdata=%h want 1 1 00",
                            bus.resp_valid, bus.resp_write, bus.resp_rdata);
      end
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W+DATA_W:0] q[$];
      logic [ADDR_W+DATA_W:0] e;
      logic                   w;
      logic [ADDR_W-1:0]      a;
      logic [DATA_W-1:0]      d;
      logic [DATA_W-1:0]      rd;
      int n;
      bus.resp_ready = 1'b1;
      bus.sm_finish  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w = 1'($urandom);
         a = ADDR_W'($urandom);
         d = DATA_W'($urandom);
         checks++;
         if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.req_ready); end
         q.push_back({w, a, d});
         send_req(w, a, d);
      end
      checks++;
      if ({bus.req_ready, busy} !== 2'b01) begin
         errors++; $display("FAIL b2b_full: req_ready,busy=%b want 01", {bus.req_ready, busy});
      end
      for (int i = 0; i < 5; i++) begin
         n = 0;
         while (!bus.sm_core_val && n < 20) begin @(negedge clock); n++; end
         e = q.pop_front();
         checks++;
         if ({bus.sm_core_val, bus.sm_write, bus.sm_addr, bus.sm_wdata} !== {1'b1, e}) begin
            errors++; $display("FAIL b2b_issue[%0d]: val=%b got %h want %h", i, bus.sm_core_val,
                               {bus.sm_write, bus.sm_addr, bus.sm_wdata}, e);
         end
         rd = DATA_W'($urandom);
         bus.sm_finish = 1'b1;
         bus.sm_rdata  = rd;
         @(negedge clock);
         bus.sm_finish = 1'b0;
         checks++;
         if ({bus.resp_valid, bus.resp_write, bus.resp_rdata} !== {1'b1, e[ADDR_W+DATA_W], e[ADDR_W+DATA_W] ? 8'h00 : rd}) begin
            errors++; $display("FAIL b2b_resp[%0d]: rv=%b rw=%b rdata=%h want 1 %b %h", i, bus.resp_valid,
                               bus.resp_write, bus.resp_rdata, e[ADDR_W+DATA_W], e[ADDR_W+DATA_W] ? 8'h00 : rd);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_backpressure();
      logic [ADDR_W-1:0] a0;
      logic [ADDR_W-1:0] a1;
      logic [DATA_W-1:0] d;
      int n;
      a0 = ADDR_W'($urandom);
      a1 = ADDR_W'($urandom);
      d  = DATA_W'($urandom_range(255, 1));
      bus.resp_ready = 1'b0;
      send_req(1'b0, a0, 8'h00);
      send_req(1'b0, a1, 8'h00);
      n = 0;
      while (!bus.sm_core_val && n < 20) begin @(negedge clock); n++; end
      checks++;
      if (bus.sm_addr !== a0) begin errors++; $display("FAIL bp_first_addr: got %h want %h", bus.sm_addr, a0); end
      bus.sm_finish = 1'b1;
      bus.sm_rdata  = d;
      @(negedge clock);
      bus.sm_finish = 1'b0;
      bus.sm_rdata  = ~d;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if ({bus.resp_valid, bus.resp_write, bus.resp_rdata, bus.sm_core_val} !== {2'b10, d, 1'b0}) begin
            errors++; $display("FAIL bp_hold[%0d]: rv=%b rw=%b rdata=%h core_val=%b want 1 0 %h 0", k,
                               bus.resp_valid, bus.resp_write, bus.resp_rdata, bus.sm_core_val, d);
         end
         @(negedge clock);
      end
      bus.resp_ready = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: resp_valid=%b want 0", bus.resp_valid); end
      n = 0;
      while (!bus.sm_core_val && n < 20) begin @(negedge clock); n++; end
      checks++;
      if ({bus.sm_core_val, bus.sm_addr} !== {1'b1, a1}) begin
         errors++; $display("FAIL bp_second_addr: val=%b addr=%h want 1 %h", bus.sm_core_val, bus.sm_addr, a1);
      end
      bus.sm_finish = 1'b1;
      @(negedge clock);
      bus.sm_finish = 1'b0;
      checks++;
      if ({bus.resp_valid, bus.resp_rdata} !== {1'b1, ~d}) begin
         errors++; $display("FAIL bp_second_resp: rv=%b rdata=%h want 1 %h", bus.resp_valid, bus.resp_rdata, ~d);
      end
      @(negedge clock);
   endtask

   task automatic test_reset_mid();
      int n;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_req(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      n = 0;
      while (!bus.sm_core_val && n < 20) begin @(negedge clock); n++; end
      checks++;
      if (bus.sm_core_val !== 1'b1) begin errors++; $display("FAIL rst_pre_strobe: core_val=%b want 1", bus.sm_core_val); end
      @(posedge clock);
      #3 reset = 1'b0;
      #1;
      checks++;
      if ({bus.sm_core_val, bus.sm_read, bus.sm_write, bus.req_ready, busy, bus.resp_valid} !== 6'b000100) begin
         errors++; $display("FAIL rst_async: val/rd/wr/ready/busy/rv=%b want 000100",
                            {bus.sm_core_val, bus.sm_read, bus.sm_write, bus.req_ready, busy, bus.resp_valid});
      end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 20; k++) begin
         bus.sm_finish = 1'($urandom);
         @(negedge clock);
         checks++;
         if ({bus.resp_valid, bus.sm_core_val, busy} !== 3'b000) begin
            errors++; $display("FAIL rst_after[%0d]: rv,core_val,busy=%b want 000", k, {bus.resp_valid, bus.sm_core_val, busy});
         end
      end
      bus.sm_finish = 1'b0;
      @(negedge clock);
   endtask

`ifdef SMEM_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      int len;
      bus.resp_ready = 1'b0;
      bus.sm_rdata   = 8'h7E;
      send_req(1'b0, 12'h2A0, 8'h00);
      n = 0;
      while (!bus.sm_core_val && n < 20) begin @(negedge clock); n++; end
      len = 0;
      while (bus.sm_core_val && len < 100) begin @(negedge clock); len++; end
      checks++;
      if (len != TMO) begin errors++; $display("FAIL tmo_len: strobe cycles %0d want %0d", len, TMO); end
      checks++;
      if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {2'b11, 8'h00}) begin
         errors++; $display("FAIL tmo_resp: rv=%b err=%b rdata=%h want 1 1 00", bus.resp_valid, bus.resp_err, bus.resp_rdata);
      end
      bus.resp_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
   endtask
`else
   task automatic test_no_timeout();
      int n;
      bus.resp_ready = 1'b1;
      bus.sm_rdata   = 8'h7E;
      send_req(1'b0, 12'h2A0, 8'h00);
      n = 0;
      while (!bus.sm_core_val && n < 20) begin @(negedge clock); n++; end
      for (int k = 0; k < 40; k++) begin
         checks++;
         if ({bus.sm_core_val, bus.resp_valid, bus.resp_err} !== 3'b100) begin
            errors++; $display("FAIL notmo_wait[%0d]: core_val,rv,err=%b want 100", k,
                               {bus.sm_core_val, bus.resp_valid, bus.resp_err});
         end
         @(negedge clock);
      end
      bus.sm_finish = 1'b1;
      @(negedge clock);
      bus.sm_finish = 1'b0;
      checks++;
      if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {2'b10, 8'h7E}) begin
         errors++; $display("FAIL notmo_resp: rv=%b err=%b rdata=%h want 1 0 7e", bus.resp_valid, bus.resp_err, bus.resp_rdata);
      end
      @(negedge clock);
   endtask
`endif

   task automatic test_random_traffic();
      logic [ADDR_W+DATA_W:0] exp_issue[$];
      logic [DATA_W:0]        exp_resp[$];
      logic [ADDR_W+DATA_W:0] cur;
      logic [DATA_W-1:0]      mem_data;
      logic                   mem_active;
      logic                   fin_sent;
      logic                   w;
      int lat_left;
      int fin_left;
      int accepted;
      int answered;
      mem_active = 1'b0;
      fin_sent   = 1'b0;
      lat_left   = 0;
      fin_left   = 0;
      accepted   = 0;
      answered   = 0;
      cur        = '0;
      mem_data   = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clock);
         if (bus.resp_valid) begin
            checks++;
            if (exp_resp.size() == 0) begin
               errors++; $display("FAIL rnd_resp_unexpected: rw=%b rdata=%h want no response", bus.resp_write, bus.resp_rdata);
            end else if ({bus.resp_write, bus.resp_rdata, bus.resp_err} !== {exp_resp[0], 1'b0}) begin
               errors++; $display("FAIL rnd_resp: rw/rdata/err=%h want %h", {bus.resp_write, bus.resp_rdata, bus.resp_err},
                                  {exp_resp[0], 1'b0});
            end
         end
         if (!bus.sm_core_val) mem_active = 1'b0;
         if (bus.sm_core_val && !mem_active) begin
            checks++;
            if (exp_issue.size() == 0) begin
               errors++; $display("FAIL rnd_issue_unexpected: addr=%h want no strobe", bus.sm_addr);
            end else begin
               cur = exp_issue.pop_front();
               if ({bus.sm_write, bus.sm_addr, bus.sm_wdata, bus.sm_read, bus.sm_finish} !== {cur, ~cur[ADDR_W+DATA_W], 1'b0}) begin
                  errors++; $display("FAIL rnd_issue: wr/addr/wdata/rd/fin=%h want %h", {bus.sm_write, bus.sm_addr,
                                     bus.sm_wdata, bus.sm_read, bus.sm_finish}, {cur, ~cur[ADDR_W+DATA_W], 1'b0});
               end
            end
            mem_active = 1'b1;
            fin_sent   = 1'b0;
            lat_left   = int'($urandom_range(5, 0));
            mem_data   = DATA_W'($urandom);
         end else if (bus.sm_core_val) begin
            checks++;
            if ({bus.sm_write, bus.sm_addr, bus.sm_wdata, bus.sm_read} !== {cur, ~cur[ADDR_W+DATA_W]}) begin
               errors++; $display("FAIL rnd_hold: wr/addr/wdata/rd=%h want %h", {bus.sm_write, bus.sm_addr,
                                  bus.sm_wdata, bus.sm_read}, {cur, ~cur[ADDR_W+DATA_W]});
            end
         end
         if (mem_active && !fin_sent) begin
            if (lat_left == 0) begin
               w = cur[ADDR_W+DATA_W];
               bus.sm_finish = 1'b1;
               bus.sm_rdata  = mem_data;
               fin_sent      = 1'b1;
               fin_left      = int'($urandom_range(3, 0));
               exp_resp.push_back({w, w ? 8'h00 : mem_data});
            end else begin
               lat_left--;
               bus.sm_finish = 1'b0;
               bus.sm_rdata  = DATA_W'($urandom);
            end
         end else if (fin_left > 0) begin
            bus.sm_finish = 1'b1;
            fin_left--;
         end else begin
            bus.sm_finish = 1'b0;
            bus.sm_rdata  = DATA_W'($urandom);
         end
         bus.resp_ready = ($urandom_range(9, 0) < 6);
         if (bus.resp_valid && bus.resp_ready && exp_resp.size() > 0) begin
            void'(exp_resp.pop_front());
            answered++;
         end
         bus.req_valid = (cyc < 800) && ($urandom_range(9, 0) < 7);
         bus.req_write = 1'($urandom);
         bus.req_addr  = ADDR_W'($urandom);
         bus.req_wdata = DATA_W'($urandom);
         if (bus.req_valid && bus.req_ready) begin
            exp_issue.push_back({bus.req_write, bus.req_addr, bus.req_wdata});
            accepted++;
         end
         if (cyc >= 800 && exp_issue.size() == 0 && exp_resp.size() == 0 && !mem_active &&
             fin_left == 0 && !busy && !bus.sm_finish) break;
      end
      bus.req_valid = 1'b0;
      checks++;
      if (accepted != answered || exp_issue.size() != 0 || exp_resp.size() != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL rnd_drain: accepted=%0d answered=%0d pend_issue=%0d pend_resp=%0d busy=%b want equal, 0, 0, 0",
                            accepted, answered, exp_issue.size(), exp_resp.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load_drain();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
`ifdef SMEM_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_random_traffic();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/smem_core_port.md
Name: smem_core_port

Overview:
- Per-core request front-end placed directly upstream of the 16-port shared memory; one instance per core (lanes 0..15).
- Accepts load/store requests from the core LSU via valid/ready and buffers them in a small in-order FIFO.
- Issues one request at a time onto the shared-memory read/write/core_val/addr/data lane and holds it stable until finish.
- Returns read data or a store acknowledge to the core via a valid/ready response channel.

Parameters:
- ADDR_W, 12, shared-memory address width.
- DATA_W, 8, data width.
- FIFO_DEPTH, 4, request FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 255, BUSY cycles before abort; used only with SMEM_TIMEOUT_EN.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  FIFO not full.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts response.
- resp_write  out  1  response belongs to a store.
- resp_rdata  out  DATA_W  load data; 0 for stores.
- resp_err  out  1  request aborted by timeout.
- sm_read  out  1  to shared memory read_n.
- sm_write  out  1  to shared memory write_n.
- sm_core_val  out  1  to shared memory core_val_n.
- sm_addr  out  ADDR_W  to addr_in_n.
- sm_wdata  out  DATA_W  to data_in_n.
- sm_rdata  in  DATA_W  from data_out_n.
- sm_finish  in  1  from finish_n; registered, may stay high several cycles.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (reset=0, async): FIFO empty, FSM=IDLE.
  - All outputs 0 except req_ready=1.
  - Reset mid-transaction drops the in-flight request and all queued requests silently; no response is produced.
- FIFO:
  - Write on req_valid&&req_ready.
  - Not fall-through. Pointers log2(FIFO_DEPTH) bits plus a wrap bit.
  - req_ready = !full, registered-count based. A simultaneous push and pop when full is not allowed because ready is 0.
- FSM states IDLE, BUSY, RESP, DRAIN:
  - IDLE: if FIFO non-empty, pop head into issue registers and go to BUSY. Outputs register from the issue registers, so sm_read/sm_write rise the cycle after the pop. Earliest strobe is 2 cycles after acceptance.
  - BUSY: sm_core_val=1; exactly one of sm_read/sm_write = 1; sm_addr/sm_wdata held constant.
    - On sm_finish=1: capture sm_rdata (loads only, else 0), clear strobes and sm_core_val the next cycle, go to RESP.
  - RESP: resp_valid=1 with resp_write/resp_rdata/resp_err stable.
    - On resp_ready: drop resp_valid next cycle; go to DRAIN if sm_finish=1, else IDLE.
  - DRAIN: wait until sm_finish=0, then go to IDLE. This guarantees at least one idle cycle between requests so a stale finish never completes the next request.
- sm_finish outside BUSY is ignored.
- The FIFO keeps accepting requests in every state.
- Ordering is strict FIFO; responses are never reordered.

Optional Feature:
- Macro SMEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no finish: drop strobes, go to RESP with resp_err=1, resp_rdata=0.
  - A finish arriving in the same cycle as the timeout wins, with resp_err=0.
- Undefined: no counter; resp_err tied 0; BUSY waits indefinitely.

Test Plan:
- Store: req_write=1, addr=0x123, wdata=0xA5; finish pulses 3 cycles after the strobe -> sm_write=1, sm_addr=0x123, sm_wdata=0xA5 from cycle 2; one response with resp_write=1, resp_rdata=0.
- Load with finish held high 4 cycles, data 0x5C -> resp_rdata=0x5C; DRAIN holds until finish=0; the next queued request strobes only after that.
- Push 5 back-to-back requests with FIFO_DEPTH=4 and finish never asserted -> req_ready=0 after the 5th accept (4 queued plus 1 in BUSY); then release finish -> 5 responses in order.
- Response backpressure: resp_ready=0 for 10 cycles -> resp_valid and data stay stable, no new strobe; resp_ready=1 -> next request proceeds.
- Reset asserted during BUSY with 2 queued -> strobes 0 immediately (async), req_ready=1, busy=0, no response after release.
- SMEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, finish never asserted -> exactly 16 BUSY cycles, then response with resp_err=1, resp_rdata=0.
